// File: rtl/axi_reg_slice.sv
// axi_reg_slice: full-throughput AXI4-Stream register slice (skid buffer)
//   clk      - system clock, all state on the rising edge
//   rst      - synchronous active-low reset
//   s_tdata/s_tvalid/s_tlast in, s_tready out (registered) - upstream stream
//   m_tdata/m_tvalid/m_tlast out (registered), m_tready in - downstream stream
module axi_reg_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready
);
   logic [DW-1:0] m_tdata_q, m_tdata_d, skid_data_q, skid_data_d;
   logic          m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
   logic          skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
   logic          s_tready_q, s_tready_d;
   logic          s_xfer, out_free;
   always_comb begin
      s_xfer       = s_tvalid & s_tready_q;
      out_free     = !m_tvalid_q | m_tready;
      // skid beat is older than anything on the input, so it always wins the output
      m_tvalid_d   = out_free ? (skid_valid_q | s_xfer) : m_tvalid_q;
      m_tdata_d    = !out_free ? m_tdata_q : skid_valid_q ? skid_data_q : s_xfer ? s_tdata : m_tdata_q;
      m_tlast_d    = !out_free ? m_tlast_q : skid_valid_q ? skid_last_q : s_xfer ? s_tlast : m_tlast_q;
      skid_valid_d = out_free ? 1'b0 : (skid_valid_q | s_xfer);
      skid_data_d  = (!out_free & s_xfer) ? s_tdata : skid_data_q;
      skid_last_d  = (!out_free & s_xfer) ? s_tlast : skid_last_q;
      // ready is a register copy of "skid will be empty", keeping tready free of comb paths
      s_tready_d   = !skid_valid_d;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_tdata_q    <= '0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         s_tready_q   <= 1'b0;
      end else begin
         m_tdata_q    <= m_tdata_d;
         m_tvalid_q   <= m_tvalid_d;
         m_tlast_q    <= m_tlast_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         skid_valid_q <= skid_valid_d;
         s_tready_q   <= s_tready_d;
      end
   end
   assign s_tready = s_tready_q;
   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: scoreboard-driven bench for axi_reg_slice
module tb_axi_reg_slice;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_tdata = '0;
   logic       s_tvalid = 1'b0;
   logic       s_tlast = 1'b0;
   logic       s_tready;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready = 1'b0;
   typedef struct packed {logic [7:0] d; logic l;} beat_t;
   beat_t sb[$];
   int checks = 0;
   int fails = 0;
   always #5 clk = ~clk;
   axi_reg_slice #(.DW(8)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
   );
   task automatic test_reset;
      rst = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hAA; s_tlast = 1'b1; m_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL reset_m_tdata: got %h expected 00", m_tdata); end
      checks++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); end
      checks++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
      @(posedge clk); #1;
      checks++; if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_release_s_tready: got %b expected 1", s_tready); end
   endtask
   task automatic test_streaming;
      int idx, outs, cyc;
      beat_t exp;
      idx = 0; outs = 0; cyc = 0;
      m_tready = 1'b1;
      while (outs < 10 && cyc < 50) begin
         s_tvalid = idx < 10; s_tdata = 8'(2 * idx + 2); s_tlast = idx == 9;
         @(negedge clk);
         if (outs > 0 && outs < 10) begin
            checks++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL stream_bubble: got m_tvalid %b expected 1 at cycle %0d", m_tvalid, cyc); end
         end
         if (m_tvalid && m_tready) begin
            checks++; outs++;
            if (sb.size() == 0) begin fails++; $display("FAIL stream_beat: got %h/%b expected no beat", m_tdata, m_tlast); end
            else begin
               exp = sb.pop_front();
               if ({m_tdata, m_tlast} !== {exp.d, exp.l}) begin fails++; $display("FAIL stream_beat: got %h/%b expected %h/%b", m_tdata, m_tlast, exp.d, exp.l); end
            end
         end
         if (s_tvalid && s_tready) begin sb.push_back({s_tdata, s_tlast}); idx++; end
         @(posedge clk); #1; cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++; if (cyc != 11) begin fails++; $display("FAIL stream_latency: got %0d cycles expected 11", cyc); end
      checks++; if (sb.size() != 0 || outs != 10) begin fails++; $display("FAIL stream_drain: got %0d beats out, %0d left expected 10, 0", outs, sb.size()); end
   endtask
   task automatic test_backpressure;
      int idx, outs, cyc, stall_acc;
      logic [7:0] held;
      beat_t exp;
      idx = 0; outs = 0; cyc = 0; stall_acc = 0; held = '0;
      while (outs < 10 && cyc < 60) begin
         s_tvalid = idx < 10; s_tdata = 8'(2 * idx + 2); s_tlast = idx == 9;
         m_tready = !(cyc >= 3 && cyc <= 6);
         @(negedge clk);
         if (cyc >= 3 && cyc <= 6) begin
            if (s_tvalid && s_tready) stall_acc++;
            if (cyc == 3) held = m_tdata;
            else begin
               checks++; if (m_tdata !== held || m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_hold: got %h/%b expected %h/1", m_tdata, m_tvalid, held); end
               checks++; if (s_tready !== 1'b0) begin fails++; $display("FAIL bp_s_tready: got %b expected 0 at cycle %0d", s_tready, cyc); end
            end
         end
         if (m_tvalid && m_tready) begin
            checks++; outs++;
            if (sb.size() == 0) begin fails++; $display("FAIL bp_beat: got %h/%b expected no beat", m_tdata, m_tlast); end
            else begin
               exp = sb.pop_front();
               if ({m_tdata, m_tlast} !== {exp.d, exp.l}) begin fails++; $display("FAIL bp_beat: got %h/%b expected %h/%b", m_tdata, m_tlast, exp.d, exp.l); end
            end
         end
         if (s_tvalid && s_tready) begin sb.push_back({s_tdata, s_tlast}); idx++; end
         @(posedge clk); #1; cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      checks++; if (stall_acc != 1) begin fails++; $display("FAIL bp_absorb: got %0d beats during stall expected 1", stall_acc); end
      checks++; if (sb.size() != 0 || outs != 10) begin fails++; $display("FAIL bp_drain: got %0d beats out, %0d left expected 10, 0", outs, sb.size()); end
   endtask
   task automatic test_startup_stall;
      int outs;
      beat_t exp;
      outs = 0;
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'd2; s_tlast = 1'b0;
      @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin fails++; $display("FAIL stall_ready0: got %b expected 1", s_tready); end
      if (s_tvalid && s_tready) sb.push_back({s_tdata, s_tlast});
      @(posedge clk); #1;
      s_tdata = 8'd4; s_tlast = 1'b1;
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'd2) begin fails++; $display("FAIL stall_first: got %b/%h expected 1/02", m_tvalid, m_tdata); end
      if (s_tvalid && s_tready) sb.push_back({s_tdata, s_tlast});
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      @(negedge clk);
      checks++; if (s_tready !== 1'b0 || m_tdata !== 8'd2) begin fails++; $display("FAIL stall_full: got ready %b data %h expected 0/02", s_tready, m_tdata); end
      @(posedge clk); #1;
      m_tready = 1'b1;
      for (int c = 0; c < 10 && outs < 2; c++) begin
         @(negedge clk);
         if (outs == 1) begin
            checks++; if (s_tready !== 1'b1) begin fails++; $display("FAIL stall_reready: got %b expected 1", s_tready); end
         end
         if (m_tvalid && m_tready) begin
            checks++; outs++;
            if (sb.size() == 0) begin fails++; $display("FAIL stall_beat: got %h/%b expected no beat", m_tdata, m_tlast); end
            else begin
               exp = sb.pop_front();
               if ({m_tdata, m_tlast} !== {exp.d, exp.l}) begin fails++; $display("FAIL stall_beat: got %h/%b expected %h/%b", m_tdata, m_tlast, exp.d, exp.l); end
            end
         end
         @(posedge clk); #1;
      end
      checks++; if (outs != 2 || sb.size() != 0) begin fails++; $display("FAIL stall_drain: got %0d beats out expected 2", outs); end
   endtask
   task automatic test_packets;
      int outs, cyc, lasts, i;
      beat_t exp;
      outs = 0; cyc = 0; lasts = 0;
      m_tready = 1'b1;
      while (outs < 20 && cyc < 80) begin
         i = cyc < 13 ? cyc : cyc - 13;
         s_tvalid = cyc < 10 || (cyc >= 13 && cyc < 23);
         s_tdata = 8'((cyc >= 13 ? 64 : 0) + 2 * i + 2);
         s_tlast = i == 9;
         @(negedge clk);
         if (cyc >= 11 && cyc <= 13) begin
            checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL pkt_gap: got m_tvalid %b expected 0 at cycle %0d", m_tvalid, cyc); end
         end
         if (m_tvalid && m_tlast) lasts++;
         if (m_tvalid && m_tready) begin
            checks++; outs++;
            if (sb.size() == 0) begin fails++; $display("FAIL pkt_beat: got %h/%b expected no beat", m_tdata, m_tlast); end
            else begin
               exp = sb.pop_front();
               if ({m_tdata, m_tlast} !== {exp.d, exp.l}) begin fails++; $display("FAIL pkt_beat: got %h/%b expected %h/%b", m_tdata, m_tlast, exp.d, exp.l); end
            end
         end
         if (s_tvalid && s_tready) sb.push_back({s_tdata, s_tlast});
         @(posedge clk); #1; cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++; if (lasts != 2) begin fails++; $display("FAIL pkt_tlast: got %0d pulses expected 2", lasts); end
      checks++; if (outs != 20 || sb.size() != 0) begin fails++; $display("FAIL pkt_drain: got %0d beats out expected 20", outs); end
   endtask
   task automatic test_reset_midstream;
      int outs;
      logic sent;
      beat_t exp;
      outs = 0; sent = 1'b0;
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hA1; s_tlast = 1'b0;
      @(negedge clk);
      if (s_tvalid && s_tready) sb.push_back({s_tdata, s_tlast});
      @(posedge clk); #1;
      s_tdata = 8'hA2; s_tlast = 1'b1;
      @(negedge clk);
      if (s_tvalid && s_tready) sb.push_back({s_tdata, s_tlast});
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin fails++; $display("FAIL rst_mid_full: got valid %b ready %b expected 1/0", m_tvalid, s_tready); end
      rst = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hEE;
      @(posedge clk); #1;
      checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin fails++; $display("FAIL rst_mid_ctrl: got valid %b ready %b expected 0/0", m_tvalid, s_tready); end
      checks++; if (m_tdata !== 8'h00 || m_tlast !== 1'b0) begin fails++; $display("FAIL rst_mid_data: got %h/%b expected 00/0", m_tdata, m_tlast); end
      sb.delete();
      rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_stale: got m_tvalid %b data %h expected 0", m_tvalid, m_tdata); end
         @(posedge clk); #1;
      end
      for (int c = 0; c < 10 && outs < 1; c++) begin
         s_tvalid = !sent; s_tdata = 8'h5A; s_tlast = 1'b1;
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            checks++; outs++;
            if (sb.size() == 0) begin fails++; $display("FAIL rst_mid_beat: got %h/%b expected no beat", m_tdata, m_tlast); end
            else begin
               exp = sb.pop_front();
               if ({m_tdata, m_tlast} !== {exp.d, exp.l}) begin fails++; $display("FAIL rst_mid_beat: got %h/%b expected %h/%b", m_tdata, m_tlast, exp.d, exp.l); end
            end
         end
         if (s_tvalid && s_tready) begin sb.push_back({s_tdata, s_tlast}); sent = 1'b1; end
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++; if (outs != 1 || sb.size() != 0) begin fails++; $display("FAIL rst_mid_resume: got %0d beats out expected 1", outs); end
   endtask
   initial begin
      test_reset;
      test_streaming;
      test_backpressure;
      test_startup_stall;
      test_packets;
      test_reset_midstream;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
